// File: rtl/inst_fetch_pkg.sv
// Shared RV32I front-end definitions: opcodes, reset/NOP constants and fetch FSM states.
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/imm_j_gen.sv
// J-type immediate extraction (sign-extended, byte offset); shared with the decoder.
module imm_j_gen (
  input  logic [31:0] inst,
  output logic [31:0] imm
);

  assign imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, one outstanding imem read, stall/redirect handling.
// Optional IFETCH_JAL_PREDECODE_EN: follow jal targets in fetch instead of waiting for execute.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = inst_fetch_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = inst_fetch_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic        inst_valid,
  output logic        fault
);

  state_t      state, state_nx;
  logic [31:0] pc_q, pc_nx;
  logic [31:0] inst_q, inst_nx;
  logic [31:0] pc_o, pc_o_nx;
  logic [31:0] pc4_o, pc4_o_nx;
  logic        valid_q, valid_nx;
  logic        fault_q, fault_nx;
  logic [31:0] seq_pc;

`ifdef IFETCH_JAL_PREDECODE_EN
  logic [31:0] imm_j;

  imm_j_gen u_imm_j (
    .inst (imem_rdata),
    .imm  (imm_j)
  );

  assign seq_pc = (imem_rdata[6:0] == OP_JAL) ? pc_q + imm_j : pc_plus4(pc_q);
`else
  assign seq_pc = pc_plus4(pc_q);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      pc_o    <= RESET_PC;
      pc4_o   <= RESET_PC + 32'd4;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nx;
      pc_q    <= pc_nx;
      inst_q  <= inst_nx;
      pc_o    <= pc_o_nx;
      pc4_o   <= pc4_o_nx;
      valid_q <= valid_nx;
      fault_q <= fault_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    inst_nx  = inst_q;
    pc_o_nx  = pc_o;
    pc4_o_nx = pc4_o;
    valid_nx = 1'b0;
    fault_nx = fault_q;

    case (state)
      ST_IDLE: state_nx = ST_REQ;
      ST_REQ:  state_nx = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid) begin
          inst_nx  = imem_rdata;
          pc_o_nx  = pc_q;
          pc4_o_nx = pc_plus4(pc_q);
          valid_nx = 1'b1;
          pc_nx    = seq_pc;
          state_nx = stall ? ST_HOLD : ST_REQ;
        end
      end
      ST_HOLD: begin
        valid_nx = stall;
        if (!stall) state_nx = ST_REQ;
      end
      ST_DRAIN: if (imem_rvalid) state_nx = ST_REQ;
      ST_HALT:  state_nx = ST_HALT;
      default:  state_nx = ST_IDLE;
    endcase

    // Redirect overrides everything above; a response captured this cycle is discarded.
    if (redirect_en && state != ST_HALT) begin
      valid_nx = 1'b0;
      inst_nx  = NOP_INST;
      pc_o_nx  = pc_o;
      pc4_o_nx = pc4_o;
      pc_nx    = pc_q;
      if (redirect_pc[1:0] != 2'b00) begin
        fault_nx = 1'b1;
        state_nx = ST_HALT;
      end else begin
        pc_nx = redirect_pc;
        case (state)
          ST_REQ:   state_nx = ST_DRAIN;
          ST_WAIT:  state_nx = imem_rvalid ? ST_REQ : ST_DRAIN;
          ST_DRAIN: state_nx = imem_rvalid ? ST_REQ : ST_DRAIN;
          default:  state_nx = ST_REQ;
        endcase
      end
    end
  end

  assign imem_req   = (state == ST_REQ);
  assign imem_addr  = pc_q;
  assign inst       = valid_q ? inst_q : NOP_INST;
  assign pc         = pc_o;
  assign pc_4       = pc4_o;
  assign inst_valid = valid_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized run against a
// transaction-level fetch model. Honours IFETCH_JAL_PREDECODE_EN the same way as the design.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_rvalid = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] inst, pc, pc_4;
  logic        inst_valid, fault;

  int checks = 0;
  int passed = 0;

  // memory responder state
  int          lat_min = 1, lat_max = 1;
  bit          fixed_en = 1'b0;
  logic [31:0] fixed_data = NOP;
  bit          pending = 1'b0;
  int          cnt = 0;
  logic [31:0] req_addr = 32'h0;
  bit          req_seen = 1'b0;
  bit          req_overlap = 1'b0;
  bit          resp_now = 1'b0;
  logic [31:0] resp_addr = 32'h0;
  logic [31:0] last_data = 32'h0;

  inst_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .pc          (pc),
    .pc_4        (pc_4),
    .inst_valid  (inst_valid),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    r[6:0] = ($urandom_range(7, 0) == 0) ? 7'b1101111 : 7'b0010011;
    return r;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] a, input logic [31:0] i);
`ifdef IFETCH_JAL_PREDECODE_EN
    if (i[6:0] == 7'b1101111) begin
      logic [20:0] off;
      off = {i[31], i[19:12], i[20], i[30:21], 1'b0};
      return a + {{11{off[20]}}, off};
    end
`endif
    return a + 32'd4;
  endfunction

  // Advance to the next falling edge and play the instruction memory for one cycle.
  task automatic step();
    @(negedge clk);
    imem_rvalid = 1'b0;
    resp_now    = 1'b0;
    if (pending) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        pending     = 1'b0;
        resp_now    = 1'b1;
        resp_addr   = req_addr;
        last_data   = fixed_en ? fixed_data : rand_inst();
        imem_rdata  = last_data;
        imem_rvalid = 1'b1;
      end
    end
    req_seen    = (imem_req === 1'b1);
    req_overlap = req_seen && pending;
    if (req_seen) begin
      pending  = 1'b1;
      cnt      = $urandom_range(lat_max, lat_min);
      req_addr = imem_addr;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stall = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    repeat (5) step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    checks++; if (inst_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", inst_valid); else passed++;
    checks++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", imem_req); else passed++;
    checks++; if (fault !== 1'b0) $display("FAIL reset_fault got %b want 0", fault); else passed++;
    checks++; if (inst !== NOP) $display("FAIL reset_inst got %h want %h", inst, NOP); else passed++;
    checks++; if (pc !== RST_PC) $display("FAIL reset_pc got %h want %h", pc, RST_PC); else passed++;
    checks++; if (pc_4 !== RST_PC + 32'd4) $display("FAIL reset_pc4 got %h want %h", pc_4, RST_PC + 32'd4); else passed++;
    checks++; if (imem_addr !== RST_PC) $display("FAIL reset_addr got %h want %h", imem_addr, RST_PC); else passed++;
    rst = 1'b1;
    step();
    checks++; if (!req_seen) $display("FAIL reset_first_req got %b want 1", imem_req); else passed++;
  endtask

  task automatic test_first_fetch();
    lat_min = 1; lat_max = 1; fixed_en = 1'b1; fixed_data = NOP;
    do_reset();
    step();
    checks++; if (!req_seen || imem_addr !== RST_PC) $display("FAIL first_addr got req=%b %h want 1 %h", req_seen, imem_addr, RST_PC); else passed++;
    step();
    checks++; if (inst_valid !== 1'b0) $display("FAIL first_early_valid got %b want 0", inst_valid); else passed++;
    step();
    checks++; if (inst_valid !== 1'b1) $display("FAIL first_valid got %b want 1", inst_valid); else passed++;
    checks++; if (pc !== RST_PC || pc_4 !== RST_PC + 32'd4 || inst !== NOP)
      $display("FAIL first_data got pc=%h pc_4=%h inst=%h want %h %h %h", pc, pc_4, inst, RST_PC, RST_PC + 32'd4, NOP); else passed++;
    checks++; if (!req_seen || imem_addr !== RST_PC + 32'd4) $display("FAIL first_next_addr got req=%b %h want 1 %h", req_seen, imem_addr, RST_PC + 32'd4); else passed++;
    step();
    checks++; if (inst_valid !== 1'b0) $display("FAIL first_pulse got %b want 0", inst_valid); else passed++;
  endtask

  task automatic test_stall();
    lat_min = 1; lat_max = 1; fixed_en = 1'b0;
    do_reset();
    step();
    stall = 1'b1;
    step();
    step();
    checks++; if (inst_valid !== 1'b1 || pc !== RST_PC || inst !== last_data)
      $display("FAIL stall_capture got v=%b pc=%h inst=%h want 1 %h %h", inst_valid, pc, inst, RST_PC, last_data); else passed++;
    for (int j = 0; j < 3; j++) begin
      step();
      checks++; if (inst_valid !== 1'b1 || req_seen || pc !== RST_PC || pc_4 !== RST_PC + 32'd4 || inst !== last_data)
        $display("FAIL stall_hold%0d got v=%b req=%b pc=%h inst=%h want 1 0 %h %h", j, inst_valid, req_seen, pc, inst, RST_PC, last_data); else passed++;
    end
    stall = 1'b0;
    step();
    checks++; if (!req_seen || imem_addr !== RST_PC + 32'd4 || inst_valid !== 1'b0)
      $display("FAIL stall_release got req=%b addr=%h v=%b want 1 %h 0", req_seen, imem_addr, inst_valid, RST_PC + 32'd4); else passed++;
  endtask

  task automatic test_redirect();
    lat_min = 3; lat_max = 3; fixed_en = 1'b0;
    do_reset();
    step();
    step();
    redirect_en = 1'b1; redirect_pc = 32'h0040_0100;
    step();
    redirect_en = 1'b0;
    checks++; if (req_seen || inst_valid !== 1'b0) $display("FAIL redir_drain got req=%b v=%b want 0 0", req_seen, inst_valid); else passed++;
    step();
    lat_min = 1; lat_max = 1;
    checks++; if (!resp_now || inst_valid !== 1'b0 || req_seen) $display("FAIL redir_stale got rv=%b v=%b req=%b want 1 0 0", resp_now, inst_valid, req_seen); else passed++;
    step();
    checks++; if (!req_seen || imem_addr !== 32'h0040_0100 || inst_valid !== 1'b0)
      $display("FAIL redir_addr got req=%b addr=%h v=%b want 1 00400100 0", req_seen, imem_addr, inst_valid); else passed++;
    step();
    step();
    checks++; if (inst_valid !== 1'b1 || pc !== 32'h0040_0100 || inst !== last_data)
      $display("FAIL redir_fetch got v=%b pc=%h inst=%h want 1 00400100 %h", inst_valid, pc, inst, last_data); else passed++;
  endtask

  task automatic test_fault();
    lat_min = 1; lat_max = 1; fixed_en = 1'b0;
    do_reset();
    step();
    redirect_en = 1'b1; redirect_pc = 32'h0040_0102;
    step();
    redirect_en = 1'b0;
    checks++; if (fault !== 1'b1 || req_seen || inst_valid !== 1'b0)
      $display("FAIL fault_set got fault=%b req=%b v=%b want 1 0 0", fault, req_seen, inst_valid); else passed++;
    for (int j = 0; j < 4; j++) begin
      redirect_en = (j == 1); redirect_pc = 32'h0040_0200;
      step();
      checks++; if (fault !== 1'b1 || req_seen || inst_valid !== 1'b0)
        $display("FAIL fault_halt%0d got fault=%b req=%b v=%b want 1 0 0", j, fault, req_seen, inst_valid); else passed++;
    end
    redirect_en = 1'b0;
    do_reset();
    checks++; if (fault !== 1'b0) $display("FAIL fault_clear got %b want 0", fault); else passed++;
  endtask

  task automatic test_jal();
    logic [31:0] want;
`ifdef IFETCH_JAL_PREDECODE_EN
    want = 32'h0040_0018;
`else
    want = 32'h0040_0024;
`endif
    lat_min = 1; lat_max = 1; fixed_en = 1'b1; fixed_data = 32'hff9f_f06f;
    do_reset();
    redirect_en = 1'b1; redirect_pc = 32'h0040_0020;
    step();
    redirect_en = 1'b0;
    checks++; if (!req_seen || imem_addr !== 32'h0040_0020) $display("FAIL jal_req got req=%b %h want 1 00400020", req_seen, imem_addr); else passed++;
    step();
    step();
    checks++; if (inst_valid !== 1'b1 || pc !== 32'h0040_0020 || pc_4 !== 32'h0040_0024 || inst !== 32'hff9f_f06f)
      $display("FAIL jal_out got v=%b pc=%h pc_4=%h inst=%h want 1 00400020 00400024 ff9ff06f", inst_valid, pc, pc_4, inst); else passed++;
    checks++; if (!req_seen || imem_addr !== want) $display("FAIL jal_next got req=%b %h want 1 %h", req_seen, imem_addr, want); else passed++;
  endtask

  task automatic test_wrap_and_async_reset();
    lat_min = 1; lat_max = 1; fixed_en = 1'b1; fixed_data = NOP;
    do_reset();
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_en = 1'b0;
    checks++; if (!req_seen || imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req got req=%b %h want 1 fffffffc", req_seen, imem_addr); else passed++;
    step();
    lat_min = 3; lat_max = 3;
    step();
    checks++; if (inst_valid !== 1'b1 || pc !== 32'hFFFF_FFFC || pc_4 !== 32'h0)
      $display("FAIL wrap_out got v=%b pc=%h pc_4=%h want 1 fffffffc 00000000", inst_valid, pc, pc_4); else passed++;
    checks++; if (!req_seen || imem_addr !== 32'h0) $display("FAIL wrap_next got req=%b %h want 1 00000000", req_seen, imem_addr); else passed++;
    step();
    #2 rst = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0 || fault !== 1'b0 || inst !== NOP ||
                  pc !== RST_PC || pc_4 !== RST_PC + 32'd4 || imem_addr !== RST_PC)
      $display("FAIL async_reset got v=%b req=%b fault=%b inst=%h pc=%h pc_4=%h addr=%h", inst_valid, imem_req, fault, inst, pc, pc_4, imem_addr); else passed++;
    for (int j = 0; j < 3; j++) begin
      step();
      checks++; if (inst_valid !== 1'b0 || req_seen) $display("FAIL late_rvalid%0d got v=%b req=%b want 0 0", j, inst_valid, req_seen); else passed++;
    end
    rst = 1'b1;
    lat_min = 1; lat_max = 1;
    step();
    checks++; if (!req_seen || imem_addr !== RST_PC || inst_valid !== 1'b0)
      $display("FAIL post_reset_req got req=%b addr=%h v=%b want 1 %h 0", req_seen, imem_addr, inst_valid, RST_PC); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] exp_fetch, e_inst, e_pc;
    bit          exp_valid, holding, stale;
    int          delivered;
    lat_min = 1; lat_max = 3; fixed_en = 1'b0;
    do_reset();
    exp_fetch = RST_PC; exp_valid = 1'b0; holding = 1'b0; stale = 1'b0; delivered = 0;
    e_inst = NOP; e_pc = RST_PC;
    for (int i = 0; i < 800; i++) begin
      step();
      checks++; if (inst_valid !== exp_valid) $display("FAIL rnd_valid@%0d got %b want %b", i, inst_valid, exp_valid); else passed++;
      if (exp_valid) begin
        checks++; if (inst !== e_inst || pc !== e_pc || pc_4 !== e_pc + 32'd4)
          $display("FAIL rnd_data@%0d got inst=%h pc=%h pc_4=%h want %h %h %h", i, inst, pc, pc_4, e_inst, e_pc, e_pc + 32'd4); else passed++;
      end
      if (req_seen) begin
        checks++; if (imem_addr !== exp_fetch || req_overlap)
          $display("FAIL rnd_req@%0d got addr=%h overlap=%b want %h 0", i, imem_addr, req_overlap, exp_fetch); else passed++;
      end
      stall       = ($urandom_range(3, 0) == 0);
      redirect_en = ($urandom_range(15, 0) == 0);
      redirect_pc = RST_PC | (32'($urandom_range(1023, 0)) << 2);
      if (redirect_en) begin
        exp_fetch = redirect_pc;
        stale     = pending;
        exp_valid = 1'b0;
        holding   = 1'b0;
      end else if (resp_now && !stale) begin
        exp_valid = 1'b1;
        e_inst    = imem_rdata;
        e_pc      = resp_addr;
        exp_fetch = model_next(resp_addr, imem_rdata);
        holding   = stall;
        delivered++;
      end else begin
        if (resp_now) stale = 1'b0;
        if (holding && stall) exp_valid = 1'b1;
        else begin
          exp_valid = 1'b0;
          holding   = 1'b0;
        end
      end
    end
    stall = 1'b0; redirect_en = 1'b0;
    checks++; if (delivered < 50) $display("FAIL rnd_progress got %0d want >=50", delivered); else passed++;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect();
    test_fault();
    test_jal();
    test_wrap_and_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
